surf_result_packer: RTL and testbench
=====================================

// Module: surf_result_packer
// PURPOSE
//  Downstream consumer of the surface accumulator (compl_surf) and plane calculator (plane_data).
//  Captures one result of each per frame and packs them into a 12-byte packet.
//  Packet carries a sync header, a sequence number, both results MSB-first and a check byte.
//  Streams the packet out over a byte-wide valid/ready interface toward the host link (UART/AXI bridge).
// PARAMETERS
//  SYNC0   8'hA5  first header byte
//  SYNC1   8'h5A  second header byte
//  DATA_W  32     width of each result word; fixed at 32 (packet length assumes 4 bytes/word)
// PORTS
//  clk          in   1   system clock (same domain as BRAM/calc pipeline)
//  rst_n        in   1   asynchronous, active-low reset
//  surf_valid   in   1   1-cycle strobe: surf_data holds a completed surface sum
//  surf_data    in   32  accumulated sphere surface (compl_surf)
//  plane_valid  in   1   1-cycle strobe: plane_data holds a completed plane result
//  plane_data   in   32  plane surface result
//  tx_data      out  8   packet byte
//  tx_valid     out  1   tx_data valid
//  tx_last      out  1   high with the final (check) byte
//  tx_ready     in   1   sink accepts byte when tx_valid && tx_ready
//  overrun      out  1   sticky: a pending result was overwritten before being sent
//  pkt_count    out  8   packets fully transmitted (wraps 8'hFF -> 8'h00)
// BEHAVIOUR
//  Reset (async, rst_n=0): tx_data=0, tx_valid=0, tx_last=0, overrun=0, pkt_count=0,
//   seq=0, both pending flags=0, FSM=IDLE. Takes effect immediately, incl. mid-packet; packet is abandoned.
//  Capture: surf_valid -> surf_hold<=surf_data, surf_pend<=1 (same for plane). If the flag is already 1
//   and the packet has not been snapshotted yet -> overwrite, overrun<=1 (sticky until reset).
//  FSM IDLE: when surf_pend && plane_pend -> snapshot {seq, surf_hold, plane_hold} into the 12-byte
//   tx buffer, clear both flags, go SEND; tx_valid=1 with SYNC0 on the next cycle (2 cycles after the
//   later strobe).
//  Simultaneous strobe and snapshot in the same cycle: the snapshot uses the old hold values; the new
//   capture wins the flag (pend stays 1, no overrun).
//  SEND: byte order SYNC0, SYNC1, seq, surf[31:24..7:0], plane[31:24..7:0], CHK (12 bytes).
//   tx_data/tx_last held stable while tx_valid && !tx_ready. Advance only on handshake; no bubbles
//   between bytes when tx_ready stays high (12 bytes in 12 cycles).
//  CHK (default): XOR of bytes 3..11 (seq through plane LSB); SYNC bytes are excluded.
//  On the CHK handshake: tx_valid<=0, seq<=seq+1 (wraps), pkt_count<=pkt_count+1, go IDLE.
//   If both flags are already set, tx_valid re-asserts (SYNC0) after one IDLE cycle.
//  Strobes that arrive during SEND are captured normally (hold registers are separate from the buffer).
//  Byte counter is 4-bit, 0..11; any value >11 is unreachable and forces IDLE.
// CONFIGURATION
//  PACKER_CRC8_EN defined: CHK = CRC-8, poly 0x07, init 0x00, no reflection, no xorout, over bytes
//   3..11, computed serially as bytes are handshaken. Packet length and timing are unchanged.
//  Not defined: CHK = XOR checksum as above; no CRC logic is synthesised.
// TESTING
//  1 Reset, surf 0x12345678 then plane 0x0000ABCD 3 cycles later, tx_ready=1 -> A5 5A 00 12 34 56 78
//    00 00 AB CD 6E; tx_last only on 6E; pkt_count=1.
//  2 Same stimulus, tx_ready toggled 1/0 each cycle -> identical byte sequence; data stable while stalled.
//  3 Two surf strobes (0x1, 0x2) before any plane strobe -> packet carries surf=0x00000002, overrun=1.
//  4 New surf+plane strobes during SEND of packet 0 -> packet 1 (seq=01) follows after one idle cycle.
//  5 rst_n low at byte 5 -> tx_valid=0 at once; after release, the next packet starts with seq=00.
//  6 PACKER_CRC8_EN defined, stimulus of test 1 -> last byte = CRC-8/0x07 of 00 12 34 56 78 00 00 AB CD
//    (reference model value); all other bytes unchanged.

Source files
------------

// File: rtl/surf_result_packer.sv
// Frame result packer: captures one surface and one plane result, then streams a 12-byte packet.
// Optional macro PACKER_CRC8_EN swaps the XOR check byte for a serial CRC-8 (poly 0x07).
module surf_result_packer #(
    parameter logic [7:0] SYNC0  = 8'hA5,
    parameter logic [7:0] SYNC1  = 8'h5A,
    parameter int         DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              surf_valid,
    input  logic [DATA_W-1:0] surf_data,
    input  logic              plane_valid,
    input  logic [DATA_W-1:0] plane_data,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    output logic              tx_last,
    input  logic              tx_ready,
    output logic              overrun,
    output logic [7:0]        pkt_count
);

    typedef enum logic {ST_IDLE = 1'b0, ST_SEND = 1'b1} state_t;

    function automatic logic [7:0] xor_chk(input logic [7:0] seq, input logic [31:0] a,
                                           input logic [31:0] b);
        return seq ^ a[31:24] ^ a[23:16] ^ a[15:8] ^ a[7:0]
                   ^ b[31:24] ^ b[23:16] ^ b[15:8] ^ b[7:0];
    endfunction

`ifdef PACKER_CRC8_EN
    function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] din);
        logic [7:0] c;
        c = crc ^ din;
        for (int i = 0; i < 8; i++) begin
            if (c[7]) begin
                c = {c[6:0], 1'b0} ^ 8'h07;
            end else begin
                c = {c[6:0], 1'b0};
            end
        end
        return c;
    endfunction
`endif

    state_t              state_r, state_nxt_s;
    logic [3:0]          byte_idx_r;
    logic [79:0]         pkt_buf_r;
    logic [7:0]          chk_r, chk_upd_s;
    logic [7:0]          seq_r, pkt_count_r;
    logic [DATA_W-1:0]   surf_hold_r, plane_hold_r;
    logic                surf_pend_r, plane_pend_r, overrun_r;
    logic [7:0]          tx_data_r;
    logic                tx_valid_r, tx_last_r;
    logic                snap_s, adv_s, done_s, abort_s;

    // Check-byte update applied on each accepted payload byte
    always_comb begin
`ifdef PACKER_CRC8_EN
        chk_upd_s = crc8_byte(chk_r, tx_data_r);
`else
        chk_upd_s = chk_r;
`endif
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state and datapath control strobes
    always_comb begin
        state_nxt_s = state_r;
        snap_s      = 1'b0;
        adv_s       = 1'b0;
        done_s      = 1'b0;
        abort_s     = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (surf_pend_r && plane_pend_r) begin
                    snap_s      = 1'b1;
                    state_nxt_s = ST_SEND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (byte_idx_r > 4'd11) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (tx_valid_r && tx_ready) begin
                    if (byte_idx_r == 4'd11) begin
                        done_s      = 1'b1;
                        state_nxt_s = ST_IDLE;
                    end else begin
                        adv_s       = 1'b1;
                        state_nxt_s = ST_SEND;
                    end
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            default: begin
                abort_s     = 1'b1;
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Result capture; a snapshot in the same cycle as a new strobe leaves the flag to the new capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            surf_hold_r  <= {DATA_W{1'b0}};
            plane_hold_r <= {DATA_W{1'b0}};
            surf_pend_r  <= 1'b0;
            plane_pend_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            if (surf_valid) begin
                surf_hold_r <= surf_data;
                surf_pend_r <= 1'b1;
            end else if (snap_s) begin
                surf_pend_r <= 1'b0;
            end else begin
                surf_pend_r <= surf_pend_r;
            end
            if (plane_valid) begin
                plane_hold_r <= plane_data;
                plane_pend_r <= 1'b1;
            end else if (snap_s) begin
                plane_pend_r <= 1'b0;
            end else begin
                plane_pend_r <= plane_pend_r;
            end
            if ((surf_valid && surf_pend_r && !snap_s) || (plane_valid && plane_pend_r && !snap_s)) begin
                overrun_r <= 1'b1;
            end else begin
                overrun_r <= overrun_r;
            end
        end
    end

    // Packet buffer, byte sequencing and registered stream outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_idx_r  <= 4'd0;
            pkt_buf_r   <= 80'd0;
            chk_r       <= 8'd0;
            seq_r       <= 8'd0;
            pkt_count_r <= 8'd0;
            tx_data_r   <= 8'd0;
            tx_valid_r  <= 1'b0;
            tx_last_r   <= 1'b0;
        end else if (snap_s) begin
            byte_idx_r <= 4'd0;
            pkt_buf_r  <= {SYNC1, seq_r, surf_hold_r, plane_hold_r};
`ifdef PACKER_CRC8_EN
            chk_r      <= 8'd0;
`else
            chk_r      <= xor_chk(seq_r, surf_hold_r, plane_hold_r);
`endif
            tx_data_r  <= SYNC0;
            tx_valid_r <= 1'b1;
            tx_last_r  <= 1'b0;
        end else if (adv_s) begin
            byte_idx_r <= byte_idx_r + 4'd1;
            pkt_buf_r  <= {pkt_buf_r[71:0], 8'd0};
            // SYNC bytes (index 0 and 1) stay out of the check
            if (byte_idx_r >= 4'd2) begin
                chk_r <= chk_upd_s;
            end else begin
                chk_r <= chk_r;
            end
            if (byte_idx_r == 4'd10) begin
                tx_data_r <= chk_upd_s;
                tx_last_r <= 1'b1;
            end else begin
                tx_data_r <= pkt_buf_r[79:72];
                tx_last_r <= 1'b0;
            end
        end else if (done_s) begin
            tx_valid_r  <= 1'b0;
            tx_last_r   <= 1'b0;
            seq_r       <= seq_r + 8'd1;
            pkt_count_r <= pkt_count_r + 8'd1;
        end else if (abort_s) begin
            tx_valid_r <= 1'b0;
            tx_last_r  <= 1'b0;
            byte_idx_r <= 4'd0;
        end else begin
            tx_valid_r <= tx_valid_r;
        end
    end

    assign tx_data   = tx_data_r;
    assign tx_valid  = tx_valid_r;
    assign tx_last   = tx_last_r;
    assign overrun   = overrun_r;
    assign pkt_count = pkt_count_r;

endmodule

// File: tb/tb_surf_result_packer.sv
// Directed bench for surf_result_packer; expected packets are hand-computed XOR values,
// with the check byte replaced by a CRC-8 reference when PACKER_CRC8_EN is defined.
module tb_surf_result_packer;

    typedef logic [7:0] pkt_t [12];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        surf_valid = 1'b0;
    logic [31:0] surf_data = 32'd0;
    logic        plane_valid = 1'b0;
    logic [31:0] plane_data = 32'd0;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_last;
    logic        tx_ready = 1'b1;
    logic        overrun;
    logic [7:0]  pkt_count;

    int n_run = 0;
    int n_fail = 0;

    surf_result_packer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .surf_valid (surf_valid),
        .surf_data  (surf_data),
        .plane_valid(plane_valid),
        .plane_data (plane_data),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .overrun    (overrun),
        .pkt_count  (pkt_count)
    );

    always #5 clk = ~clk;

    // CRC-8 reference when enabled; otherwise the hand-computed XOR byte is kept
    function automatic pkt_t with_chk(input pkt_t p);
        pkt_t q;
        q = p;
`ifdef PACKER_CRC8_EN
        begin
            logic [7:0] c;
            c = 8'h00;
            for (int i = 2; i <= 10; i++) begin
                c = c ^ q[i];
                for (int b = 0; b < 8; b++) begin
                    c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
                end
            end
            q[11] = c;
        end
`endif
        return q;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_run++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        surf_valid = 1'b0;
        plane_valid = 1'b0;
        tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic strobe(input logic s, input logic [31:0] sd, input logic p, input logic [31:0] pd);
        surf_valid = s;
        surf_data = sd;
        plane_valid = p;
        plane_data = pd;
        @(negedge clk);
        surf_valid = 1'b0;
        plane_valid = 1'b0;
    endtask

    // Receive one packet at negedges; optionally toggle ready or inject new strobes mid-packet
    task automatic collect(input string tag, input pkt_t exp, input logic toggle,
                           input logic inj, input logic [31:0] is_d, input logic [31:0] ip_d);
        int idx;
        int cyc;
        logic rdy;
        logic stalled;
        logic [7:0] held;
        logic held_last;
        idx = 0;
        cyc = 0;
        stalled = 1'b0;
        held = 8'd0;
        held_last = 1'b0;
        while (idx < 12 && cyc < 100) begin
            if (stalled) begin
                check($sformatf("%s_stall_v", tag), {31'd0, tx_valid}, 32'd1);
                check($sformatf("%s_stall_d", tag), {24'd0, tx_data}, {24'd0, held});
                check($sformatf("%s_stall_l", tag), {31'd0, tx_last}, {31'd0, held_last});
                stalled = 1'b0;
            end
            rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            tx_ready = rdy;
            surf_valid = inj && (cyc == 3);
            plane_valid = inj && (cyc == 3);
            surf_data = is_d;
            plane_data = ip_d;
            if (tx_valid) begin
                if (rdy) begin
                    check($sformatf("%s_b%0d", tag, idx), {24'd0, tx_data}, {24'd0, exp[idx]});
                    check($sformatf("%s_last%0d", tag, idx), {31'd0, tx_last}, {31'd0, (idx == 11)});
                    idx++;
                end else begin
                    held = tx_data;
                    held_last = tx_last;
                    stalled = 1'b1;
                end
            end
            @(negedge clk);
            cyc++;
        end
        surf_valid = 1'b0;
        plane_valid = 1'b0;
        tx_ready = 1'b1;
        check($sformatf("%s_done", tag), idx, 32'd12);
    endtask

    pkt_t exp1, exp3, exp4a, exp4b, exp7a, exp7b;

    initial begin
        exp1  = with_chk('{8'hA5, 8'h5A, 8'h00, 8'h12, 8'h34, 8'h56, 8'h78, 8'h00, 8'h00, 8'hAB, 8'hCD, 8'h6E});
        exp3  = with_chk('{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'hCA, 8'hFE, 8'hF0, 8'h0D, 8'hCA});
        exp4a = with_chk('{8'hA5, 8'h5A, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h88});
        exp4b = with_chk('{8'hA5, 8'h5A, 8'h01, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05});
        exp7a = with_chk('{8'hA5, 8'h5A, 8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h20, 8'h31});
        exp7b = with_chk('{8'hA5, 8'h5A, 8'h02, 8'h00, 8'h00, 8'h00, 8'h30, 8'h00, 8'h00, 8'h00, 8'h40, 8'h72});

        // Test 1: reset state, latency, nominal packet
        do_reset();
        check("rst_tx_data", {24'd0, tx_data}, 32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_tx_last", {31'd0, tx_last}, 32'd0);
        check("rst_overrun", {31'd0, overrun}, 32'd0);
        check("rst_pkt_count", {24'd0, pkt_count}, 32'd0);
        strobe(1'b1, 32'h12345678, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        strobe(1'b0, 32'd0, 1'b1, 32'h0000ABCD);
        check("t1_lat_v0", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        check("t1_lat_v1", {31'd0, tx_valid}, 32'd1);
        check("t1_lat_d", {24'd0, tx_data}, 32'h000000A5);
        collect("t1", exp1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t1_valid_end", {31'd0, tx_valid}, 32'd0);
        check("t1_pkt_count", {24'd0, pkt_count}, 32'd1);
        check("t1_overrun", {31'd0, overrun}, 32'd0);

        // Test 2: same stimulus with ready toggling
        do_reset();
        strobe(1'b1, 32'h12345678, 1'b0, 32'd0);
        repeat (2) @(negedge clk);
        strobe(1'b0, 32'd0, 1'b1, 32'h0000ABCD);
        collect("t2", exp1, 1'b1, 1'b0, 32'd0, 32'd0);
        check("t2_pkt_count", {24'd0, pkt_count}, 32'd1);

        // Test 3: surf overwritten before plane arrives
        strobe(1'b1, 32'h00000001, 1'b0, 32'd0);
        check("t3_overrun0", {31'd0, overrun}, 32'd0);
        strobe(1'b1, 32'h00000002, 1'b0, 32'd0);
        check("t3_overrun1", {31'd0, overrun}, 32'd1);
        strobe(1'b0, 32'd0, 1'b1, 32'hCAFEF00D);
        collect("t3", exp3, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t3_pkt_count", {24'd0, pkt_count}, 32'd2);
        check("t3_overrun_sticky", {31'd0, overrun}, 32'd1);

        // Test 4: new results captured during SEND, back-to-back packet after one idle cycle
        do_reset();
        check("t4_overrun_rst", {31'd0, overrun}, 32'd0);
        strobe(1'b1, 32'h11223344, 1'b1, 32'h55667788);
        collect("t4a", exp4a, 1'b0, 1'b1, 32'h0A0B0C0D, 32'h01020304);
        check("t4_idle_gap", {31'd0, tx_valid}, 32'd0);
        @(negedge clk);
        check("t4_resume_v", {31'd0, tx_valid}, 32'd1);
        collect("t4b", exp4b, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t4_pkt_count", {24'd0, pkt_count}, 32'd2);
        check("t4_overrun", {31'd0, overrun}, 32'd0);

        // Test 5: reset mid-packet abandons it immediately
        strobe(1'b1, 32'hDEADBEEF, 1'b1, 32'h00000001);
        @(negedge clk);
        check("t5_start_v", {31'd0, tx_valid}, 32'd1);
        repeat (5) @(negedge clk);
        check("t5_byte5", {24'd0, tx_data}, 32'h000000BE);
        rst_n = 1'b0;
        #1;
        check("t5_async_v", {31'd0, tx_valid}, 32'd0);
        check("t5_async_cnt", {24'd0, pkt_count}, 32'd0);
        check("t5_async_d", {24'd0, tx_data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        strobe(1'b1, 32'h12345678, 1'b1, 32'h0000ABCD);
        collect("t5", exp1, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t5_pkt_count", {24'd0, pkt_count}, 32'd1);

        // Test 7: strobe coinciding with snapshot goes to the next packet without overrun
        strobe(1'b1, 32'h00000010, 1'b1, 32'h00000020);
        strobe(1'b1, 32'h00000030, 1'b0, 32'd0);
        collect("t7a", exp7a, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t7_overrun", {31'd0, overrun}, 32'd0);
        strobe(1'b0, 32'd0, 1'b1, 32'h00000040);
        collect("t7b", exp7b, 1'b0, 1'b0, 32'd0, 32'd0);
        check("t7_pkt_count", {24'd0, pkt_count}, 32'd3);

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
